// File: rtl/rgb_pwm_pkg.sv
// Shared encodings for the RGB LED PWM controller: channel modes and
// register-select codes used by the write port.
package rgb_pwm_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_ON      = 2'd1,
        MODE_PWM     = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_t;

    localparam logic [1:0] SEL_TARGET = 2'd0;
    localparam logic [1:0] SEL_MODE   = 2'd1;
    localparam logic [1:0] SEL_RATE   = 2'd2;

endpackage

// File: rtl/rgb_pwm_chan.sv
// One LED channel: programmable registers, fade/breathe engine driven by a
// per-channel step counter, period-aligned active duty and output compare.
module rgb_pwm_chan
    import rgb_pwm_pkg::*;
#(
    parameter int               PWM_W     = 8,
    parameter logic [PWM_W-1:0] INIT_DUTY = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic [PWM_W-1:0] cnt,
    input  logic             cnt_max,
    input  logic             test_mode,
    input  logic             test_rise,
    input  logic             wr_target,
    input  logic             wr_mode,
    input  logic             wr_rate,
    input  logic [PWM_W-1:0] wr_data,
    output logic             pwm,
    output logic             fading
);

    localparam logic [PWM_W-1:0] DUTY_MAX = '1;
    localparam logic [PWM_W-1:0] ONE      = PWM_W'(1);

    logic [PWM_W-1:0] target, rate, cur_duty, act_duty, step_cnt;
    mode_t            mode;
    logic             down;

    logic [PWM_W-1:0] target_n, rate_n, cur_n, step_cnt_n;
    mode_t            mode_n, eff_mode;
    logic             down_n, step, pwm_n, fading_n;

    always_comb begin
        target_n   = wr_target ? wr_data : target;
        mode_n     = wr_mode ? mode_t'(wr_data[1:0]) : mode;
        rate_n     = wr_rate ? wr_data : rate;
        eff_mode   = test_mode ? MODE_BREATHE : mode;
        cur_n      = cur_duty;
        down_n     = down;
        step_cnt_n = step_cnt;
        step       = 1'b0;

        // rate 0 steps every clock; otherwise one step per 'rate' fade ticks
        if (rate == '0) begin
            step = 1'b1;
        end else if (tick) begin
            if (step_cnt == rate - ONE) begin
                step       = 1'b1;
                step_cnt_n = '0;
            end else begin
                step_cnt_n = step_cnt + ONE;
            end
        end

        if (step) begin
            case (eff_mode)
                MODE_PWM: begin
                    if (rate == '0)             cur_n = target;
                    else if (cur_duty < target) cur_n = cur_duty + ONE;
                    else if (cur_duty > target) cur_n = cur_duty - ONE;
                end
                MODE_BREATHE: begin
                    // turn around at the ends so the ramp never wraps
                    if (!down && cur_duty == DUTY_MAX) begin
                        cur_n  = cur_duty - ONE;
                        down_n = 1'b1;
                    end else if (down && cur_duty == '0) begin
                        cur_n  = cur_duty + ONE;
                        down_n = 1'b0;
                    end else if (down) begin
                        cur_n = cur_duty - ONE;
                    end else begin
                        cur_n = cur_duty + ONE;
                    end
                end
                default: ;
            endcase
        end

        if (wr_rate) step_cnt_n = '0;

        if (test_rise) begin
            cur_n      = INIT_DUTY;
            down_n     = 1'b0;
            step_cnt_n = '0;
        end

        fading_n = (eff_mode == MODE_PWM) && (cur_n != target_n);

        case (eff_mode)
            MODE_OFF: pwm_n = 1'b0;
            MODE_ON:  pwm_n = 1'b1;
            default:  pwm_n = (act_duty > cnt);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            target   <= '0;
            mode     <= MODE_OFF;
            rate     <= '0;
            cur_duty <= '0;
            act_duty <= '0;
            step_cnt <= '0;
            down     <= 1'b0;
            pwm      <= 1'b0;
            fading   <= 1'b0;
        end else begin
            target   <= target_n;
            mode     <= mode_n;
            rate     <= rate_n;
            cur_duty <= cur_n;
            step_cnt <= step_cnt_n;
            down     <= down_n;
            if (cnt_max) act_duty <= cur_duty;
            pwm      <= pwm_n;
            fading   <= fading_n;
        end
    end

endmodule

// File: rtl/rgb_pwm_ctrl.sv
// N-channel LED PWM controller top: fade prescaler, shared PWM counter,
// register write decode and test_mode edge detect around per-channel engines.
module rgb_pwm_ctrl
    import rgb_pwm_pkg::*;
#(
    parameter int NCH   = 3,
    parameter int PWM_W = 8,
    parameter int DIV   = 1024,
    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [CH_W-1:0]  wr_ch,
    input  logic [1:0]       wr_sel,
    input  logic [PWM_W-1:0] wr_data,
    input  logic             test_mode,
    output logic [NCH-1:0]   pwm_out,
    output logic [NCH-1:0]   fading
);

    localparam int PS_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PS_W-1:0]  ps;
    logic [PWM_W-1:0] cnt;
    logic             tick, cnt_max, test_q, test_rise, wr_ok;

    assign tick      = (ps == PS_W'(DIV - 1));
    assign cnt_max   = (cnt == '1);
    assign test_rise = test_mode & ~test_q;
    assign wr_ok     = wr_en && (int'(wr_ch) < NCH) && (wr_sel != 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            ps     <= '0;
            cnt    <= '0;
            test_q <= 1'b0;
        end else begin
            ps     <= tick ? '0 : ps + PS_W'(1);
            cnt    <= cnt + PWM_W'(1);
            test_q <= test_mode;
        end
    end

    // channel i starts its test-mode breathe at i/NCH of full scale
    for (genvar i = 0; i < NCH; i++) begin : g_chan
        logic sel_ch;
        assign sel_ch = wr_ok && (wr_ch == CH_W'(i));

        rgb_pwm_chan #(
            .PWM_W    (PWM_W),
            .INIT_DUTY(PWM_W'(i * ((2 ** PWM_W) / NCH)))
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .tick     (tick),
            .cnt      (cnt),
            .cnt_max  (cnt_max),
            .test_mode(test_mode),
            .test_rise(test_rise),
            .wr_target(sel_ch && (wr_sel == SEL_TARGET)),
            .wr_mode  (sel_ch && (wr_sel == SEL_MODE)),
            .wr_rate  (sel_ch && (wr_sel == SEL_RATE)),
            .wr_data  (wr_data),
            .pwm      (pwm_out[i]),
            .fading   (fading[i])
        );
    end

endmodule

// File: tb/tb_rgb_pwm_ctrl.sv
// Directed bench for rgb_pwm_ctrl: table of register writes with measured
// duty, plus sequences for fading, breathing, test_mode and reset.
module tb_rgb_pwm_ctrl;

    localparam int NCH   = 3;
    localparam int PWM_W = 8;
    localparam int DIV   = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [1:0] wr_ch;
    logic [1:0] wr_sel;
    logic [7:0] wr_data;
    logic       test_mode;
    logic [2:0] pwm_out;
    logic [2:0] fading;

    rgb_pwm_ctrl #(.NCH(NCH), .PWM_W(PWM_W), .DIV(DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_ch    (wr_ch),
        .wr_sel   (wr_sel),
        .wr_data  (wr_data),
        .test_mode(test_mode),
        .pwm_out  (pwm_out),
        .fading   (fading)
    );

    always #5 clk = ~clk;

    // independent count of clocks since reset release; equals the PWM counter
    int cyc;
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int    ch;
        int    sel;
        int    data;
        int    exp_high;
        string name;
    } vec_t;

    vec_t vecs[10];

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic wr(input int ch, input int sel, input int data);
        wr_en   = 1'b1;
        wr_ch   = ch[1:0];
        wr_sel  = sel[1:0];
        wr_data = data[7:0];
        step(1);
        wr_en   = 1'b0;
    endtask

    // high cycles of channel ch over one full PWM period
    task automatic measure(input int ch, output int highs);
        highs = 0;
        while (cyc % 256 != 0) step(1);
        for (int k = 0; k < 256; k++) begin
            step(1);
            highs += int'(pwm_out[ch]);
        end
    endtask

    function automatic int cur(input int ch);
        case (ch)
            0:       return int'(dut.g_chan[0].u_chan.cur_duty);
            1:       return int'(dut.g_chan[1].u_chan.cur_duty);
            default: return int'(dut.g_chan[2].u_chan.cur_duty);
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int h, prev, c, bad, maxv, t1, t2, turn_hi, turn_lo, cnt_f;

        vecs[0] = '{0, 0, 64,    64,  "duty_64"};
        vecs[1] = '{0, 0, 1,     1,   "duty_1"};
        vecs[2] = '{0, 0, 255,   255, "duty_255"};
        vecs[3] = '{3, 0, 10,    255, "bad_ch_ignored"};
        vecs[4] = '{0, 3, 10,    255, "sel3_ignored"};
        vecs[5] = '{0, 1, 1,     256, "mode_on"};
        vecs[6] = '{0, 1, 0,     0,   "mode_off"};
        vecs[7] = '{0, 1, 8'hFE, 255, "mode_upper_bits"};
        vecs[8] = '{0, 0, 0,     0,   "duty_0"};
        vecs[9] = '{0, 0, 128,   128, "duty_128"};

        rst = 1'b1; wr_en = 1'b0; wr_ch = '0; wr_sel = '0; wr_data = '0; test_mode = 1'b0;
        step(2);
        check("reset_pwm_out", int'(pwm_out), 0);
        check("reset_fading", int'(fading), 0);
        rst = 1'b0;

        wr(0, 1, 2);
        foreach (vecs[i]) begin
            wr(vecs[i].ch, vecs[i].sel, vecs[i].data);
            step(2);
            measure(0, h);
            check(vecs[i].name, h, vecs[i].exp_high);
        end

        // fade on ch1: one step per tick of 4 clocks, 10 steps
        wr(1, 1, 2);
        wr(1, 2, 1);
        wr(1, 0, 10);
        check("fade_start", int'(fading[1]), 1);
        cnt_f = 1;
        for (int k = 0; k < 59; k++) begin
            step(1);
            cnt_f += int'(fading[1]);
        end
        check_rng("fade_duration", cnt_f, 37, 40);
        check("fade_done", int'(fading[1]), 0);
        step(2);
        measure(1, h);
        check("fade_final_duty", h, 10);

        // retarget mid-fade
        wr(1, 0, 100);
        for (int k = 0; k < 400 && cur(1) != 50; k++) step(1);
        check("reach_50", cur(1), 50);
        wr(1, 0, 200);
        check_rng("retarget_no_jump", cur(1), 50, 51);
        prev = cur(1); bad = 0;
        for (int k = 0; k < 1000 && fading[1]; k++) begin
            step(1);
            c = cur(1);
            if (c < prev || c > 200) bad++;
            prev = c;
        end
        check("fade_up_monotonic", bad, 0);
        check("stop_200", cur(1), 200);
        wr(1, 0, 20);
        check("reverse_no_jump", cur(1), 200);
        check("reverse_fading", int'(fading[1]), 1);
        prev = cur(1); bad = 0;
        for (int k = 0; k < 1000 && fading[1]; k++) begin
            step(1);
            c = cur(1);
            if (c > prev || c < 20) bad++;
            prev = c;
        end
        check("fade_down_monotonic", bad, 0);
        check("stop_20", cur(1), 20);

        // breathe on ch2 at rate 0: one step per clock
        wr(2, 1, 3);
        prev = cur(2); bad = 0; maxv = 0; t1 = -1; t2 = -1; turn_hi = -1; turn_lo = -1;
        for (int k = 0; k < 1200; k++) begin
            step(1);
            c = cur(2);
            if (c - prev != 1 && prev - c != 1) bad++;
            if (prev == 255) turn_hi = c;
            if (prev == 0 && k > 2) turn_lo = c;
            if (c > maxv) maxv = c;
            if (c == 255) begin
                if (t1 < 0) t1 = k;
                else if (t2 < 0) t2 = k;
            end
            prev = c;
        end
        check("breathe_unit_steps", bad, 0);
        check("breathe_max", maxv, 255);
        check("breathe_turn_top", turn_hi, 254);
        check("breathe_turn_bottom", turn_lo, 1);
        check("breathe_period", t2 - t1, 510);

        // test_mode: phase-offset load, writes masked, resume on release
        wr(0, 1, 0);
        test_mode = 1'b1;
        step(1);
        check("tm_load_ch0", cur(0), 0);
        check("tm_load_ch1", cur(1), 85);
        check("tm_load_ch2", cur(2), 170);
        wr(0, 1, 1);
        h = 0; cnt_f = 0;
        for (int k = 0; k < 300; k++) begin
            step(1);
            h += int'(pwm_out[0]);
            cnt_f += int'(fading != 3'b000);
        end
        check("tm_write_masked", int'(h < 300), 1);
        check("tm_no_fading", cnt_f, 0);
        test_mode = 1'b0;
        step(1);
        check("tm_release_on", int'(pwm_out[0]), 1);
        check("tm_release_fading", int'(fading[1]), 1);
        h = 0;
        for (int k = 0; k < 50; k++) begin
            step(1);
            h += int'(pwm_out[0]);
        end
        check("on_constant", h, 50);

        // reset during a fade
        step(10);
        check("pre_reset_fading", int'(fading[1]), 1);
        check("pre_reset_on", int'(pwm_out[0]), 1);
        rst = 1'b1;
        step(1);
        check("mid_reset_pwm_out", int'(pwm_out), 0);
        check("mid_reset_fading", int'(fading), 0);
        rst = 1'b0;
        step(5);
        check("post_reset_pwm_out", int'(pwm_out), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rgb_pwm_ctrl.md
Name: rgb_pwm_ctrl

Overview:
Parametrised N-channel LED PWM controller. Each channel is register-programmed over a simple write port, typically from the SPI command decoder. Each channel supports off, on, PWM with hardware fading, and continuous breathe modes, plus a global test mode that forces phase-offset breathing on all channels. Outputs feed the SB_RGBA_DRV PWM inputs, which the top level instantiates.

Parameters:
NCH, 3, number of channels
PWM_W, 8, duty/PWM counter width
DIV, 1024, prescaler period in clk cycles per fade tick (>=1)

Ports:
clk  in  1  clock
rst  in  1  reset
wr_en  in  1  register write strobe, one write per cycle
wr_ch  in  $clog2(NCH) (min 1)  target channel
wr_sel  in  2  register select: 0 target duty, 1 mode, 2 fade rate, 3 reserved
wr_data  in  PWM_W  write data
test_mode  in  1  force breathe on all channels
pwm_out  out  NCH  PWM outputs, bit i = channel i
fading  out  NCH  channel i in PWM mode with cur_duty != target

Behaviour:
- Reset: rst, synchronous, active-high; clock clk. All per-channel registers clear: target=0, mode=OFF, rate=0, cur_duty=0, active duty=0, breathe dir=up. PWM counter=0, prescaler=0. pwm_out=0, fading=0.
- Writes:
  - Take effect the cycle after wr_en.
  - wr_ch>=NCH or wr_sel=3: ignored.
  - Mode uses wr_data[1:0]; upper bits are ignored.
- PWM counter: free-running PWM_W bits, shared, wraps 2^PWM_W-1 -> 0.
- Active duty: per channel, latched from cur_duty only when the counter equals 2^PWM_W-1. This makes updates glitch-free and period-aligned.
- Output: pwm_out[i] is registered = (active_duty > cnt) in PWM/BREATHE modes, so duty D gives D high cycles per 2^PWM_W.
- Modes:
  - OFF (0): output 0.
  - ON (1): output constant 1. Output switches the cycle after the mode write, not period-aligned.
  - PWM (2): cur_duty steps by 1 toward target on each channel step event.
  - BREATHE (3): cur_duty ramps 0 -> max -> 0 continuously, one step per channel step event. Direction flips on reaching 2^PWM_W-1 (going up) or 0 (going down); the value never overshoots or wraps.
  - In OFF and ON, cur_duty holds its value.
- Fade tick: prescaler counts 0..DIV-1 and pulses a tick when it wraps.
- Channel step event: per-channel counter counts ticks. A step fires when the count reaches rate, and the counter then clears. rate=0 means cur_duty <= target on the next cycle (PWM mode) and one step per clk (BREATHE mode).
- Target rewrite mid-fade: fading continues from the present cur_duty toward the new target. A rate rewrite clears the channel's step counter.
- Mode switch BREATHE->PWM: cur_duty continues from the ramp value and fades to target.
- test_mode:
  - Rising edge (registered compare): loads channel i cur_duty = i*(2^PWM_W/NCH), dir=up, clears step counters.
  - While high: all channels behave as BREATHE using their own rate. Writes still update the registers but do not affect outputs.
  - Falling edge: channels resume their programmed mode with cur_duty from the ramp.
- fading: registered, updates with cur_duty.
- Reset mid-operation: all state returns to reset values next cycle; no partial period is emitted.

Decomposition:
- Package rgb_pwm_pkg: mode encodings (MODE_OFF/ON/PWM/BREATHE) and register select encodings (SEL_TARGET/MODE/RATE).
- Sub-module rgb_pwm_chan, one instance per channel via generate. Contains the channel registers, step counter, fade/breathe engine, active-duty latch and output compare.
- The top level holds the prescaler, PWM counter, write decode and test_mode edge detect.

Test Plan:
1. Reset defaults: rst high 2 cycles -> pwm_out=0, fading=0. Then write ch0 mode=PWM, rate=0, target=64 -> from the next period start, exactly 64 high of every 256 clks.
2. Fade: DIV=4, ch1 rate=1, target 0->10 -> cur_duty steps every 4 clks, fading high ~40 clks then low. Duty-measured periods increase monotonically to 10.
3. Breathe turnaround: DIV=1, ch2 BREATHE, rate=0 -> ramp hits 255, next step 254. Ramp hits 0, next step 1. Full cycle 510 steps, never exceeding 255.
4. Mid-fade retarget: target 200 while fading up at cur=50 to 100 -> continues up from 50, stops at 200. Then retarget to 20 -> reverses without jump.
5. test_mode: assert with NCH=3 -> cur_duty loads 0/85/170. Writes during test_mode have no output effect. Deassert -> channel in ON mode outputs 1 the next cycle.
6. Boundaries: wr_ch=3 or wr_sel=3 write -> no state change. Duty 255 -> 255/256 high. ON -> constant 1. Reset asserted mid-fade -> pwm_out=0 next cycle.
